// File: rtl/mlp_argmax_if.sv
// rtl/mlp_argmax_if.sv - score stream and classification result bundle for mlp_argmax
interface mlp_argmax_if #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int IDX_WIDTH    = 4
);
  logic                    score_valid;
  logic [OUTPUT_WIDTH-1:0] score;
  logic                    mlp_done;
  logic                    busy;
  logic                    class_valid;
  logic                    class_ready;
  logic [IDX_WIDTH-1:0]    class_idx;
  logic [OUTPUT_WIDTH-1:0] class_score;
  logic                    class_err;
  logic                    dropped;

  modport master (
    output score_valid, score, mlp_done, class_ready,
    input  busy, class_valid, class_idx, class_score, class_err, dropped
  );

  modport slave (
    input  score_valid, score, mlp_done, class_ready,
    output busy, class_valid, class_idx, class_score, class_err, dropped
  );
endinterface

// File: rtl/mlp_argmax.sv
// rtl/mlp_argmax.sv - running signed argmax over MLP scores with held valid/ready result
module mlp_argmax #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int NUM_CLASSES  = 10,
  parameter int IDX_WIDTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  mlp_argmax_if.slave bus
);
  typedef enum logic {SCAN, HOLD} state_t;

  localparam logic [IDX_WIDTH-1:0] FULL_CNT = IDX_WIDTH'(NUM_CLASSES);

  state_t                  state;
  logic [IDX_WIDTH-1:0]    cnt;
  logic [OUTPUT_WIDTH-1:0] best;
  logic [IDX_WIDTH-1:0]    best_idx;
  logic                    ovr;

  logic                    busy_q;
  logic                    class_valid_q;
  logic [IDX_WIDTH-1:0]    class_idx_q;
  logic [OUTPUT_WIDTH-1:0] class_score_q;
  logic                    class_err_q;
  logic                    dropped_q;

  logic [IDX_WIDTH-1:0]    nxt_cnt;
  logic [OUTPUT_WIDTH-1:0] nxt_best;
  logic [IDX_WIDTH-1:0]    nxt_best_idx;
  logic                    nxt_ovr;

  // Scan update for this cycle's score, so a score coinciding with done is included in the result
  always_comb begin
    nxt_cnt      = cnt;
    nxt_best     = best;
    nxt_best_idx = best_idx;
    nxt_ovr      = ovr;
    if (bus.score_valid) begin
      if (cnt < FULL_CNT) begin
        // strict greater-than keeps the earlier index on ties
        if ((cnt == '0) || ($signed(bus.score) > $signed(best))) begin
          nxt_best     = bus.score;
          nxt_best_idx = cnt;
        end
        nxt_cnt = cnt + IDX_WIDTH'(1);
      end else begin
        nxt_ovr = 1'b1;
      end
    end
  end

  // SCAN/HOLD state machine with registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SCAN;
      cnt           <= '0;
      best          <= '0;
      best_idx      <= '0;
      ovr           <= 1'b0;
      busy_q        <= 1'b0;
      class_valid_q <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      class_err_q   <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          cnt      <= nxt_cnt;
          best     <= nxt_best;
          best_idx <= nxt_best_idx;
          ovr      <= nxt_ovr;
          if (bus.mlp_done) begin
            class_idx_q   <= nxt_best_idx;
            class_score_q <= nxt_best;
            class_err_q   <= (nxt_cnt != FULL_CNT) | nxt_ovr;
            class_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          // anything the MLP sends while we hold a result is lost
          if (bus.score_valid || bus.mlp_done) begin
            dropped_q <= 1'b1;
          end
          if (bus.class_ready) begin
            cnt           <= '0;
            best          <= '0;
            best_idx      <= '0;
            ovr           <= 1'b0;
            class_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state         <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.class_valid = class_valid_q;
  assign bus.class_idx   = class_idx_q;
  assign bus.class_score = class_score_q;
  assign bus.class_err   = class_err_q;
  assign bus.dropped     = dropped_q;
endmodule
